// File: rtl/sw_debouncer.sv
// sw_debouncer
//   Conditions the raw board slide switches before they reach LED_Controller,
//   clock_divider and the seg7 digit path. Each bit goes through a 2-flop
//   synchroniser and then a per-bit stability counter. A new level is accepted
//   only after it has differed from the current clean level for STABLE_CYCLES
//   consecutive clk cycles.
//
// Ports
//   clk       in   1      system clock, all state on posedge
//   rst       in   1      synchronous, active-high reset
//   sw_raw    in   WIDTH  asynchronous raw switch levels
//   sw_clean  out  WIDTH  debounced switch levels (registered)
//   sw_rise   out  WIDTH  1-cycle pulse per bit when sw_clean goes 0->1
//   sw_fall   out  WIDTH  1-cycle pulse per bit when sw_clean goes 1->0
//   changed   out  1      1-cycle pulse, OR of all sw_rise/sw_fall bits
//   busy      out  1      registered; 1 while any per-bit counter is nonzero
module sw_debouncer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    // Terminal count: the counter never exceeds this, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             changed_d;
    logic             busy_d;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = sw_clean;
        rise_d  = '0;
        fall_d  = '0;
        busy_d  = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] == sw_clean[i]) begin
                // Any agreeing cycle restarts the stability window.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                clean_d[i] = s2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            busy_d = busy_d | (cnt_d[i] != '0);
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '{default: '0};
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            changed  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            s1_q     <= sw_raw;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            sw_clean <= clean_d;
            sw_rise  <= rise_d;
            sw_fall  <= fall_d;
            changed  <= changed_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer
//   Scoreboard bench for sw_debouncer with STABLE_CYCLES=4. Stimulus tasks push
//   the expected output values for specific future cycles; tick() advances one
//   clock, samples on the falling edge and compares everything due that cycle.
module tb_sw_debouncer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STABLE = 4;

    localparam int SIG_CLEAN   = 0;
    localparam int SIG_RISE    = 1;
    localparam int SIG_FALL    = 2;
    localparam int SIG_CHANGED = 3;
    localparam int SIG_BUSY    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;
    logic             busy;

    sw_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .changed (changed),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observed(input int sig);
        case (sig)
            SIG_CLEAN:   return sw_clean;
            SIG_RISE:    return sw_rise;
            SIG_FALL:    return sw_fall;
            SIG_CHANGED: return {7'b0, changed};
            default:     return {7'b0, busy};
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_CLEAN:   return "clean";
            SIG_RISE:    return "rise";
            SIG_FALL:    return "fall";
            SIG_CHANGED: return "changed";
            default:     return "busy";
        endcase
    endfunction

    task automatic push(input int c, input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.cyc = c;
        e.tag = $sformatf("%s_%s@%0d", tag, sig_name(sig), c);
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic push_all(input int c, input string tag, input logic [7:0] clean,
                            input logic [7:0] rise, input logic [7:0] fall,
                            input logic chg, input logic bsy);
        push(c, tag, SIG_CLEAN, clean);
        push(c, tag, SIG_RISE, rise);
        push(c, tag, SIG_FALL, fall);
        push(c, tag, SIG_CHANGED, {7'b0, chg});
        push(c, tag, SIG_BUSY, {7'b0, bsy});
    endtask

    // One clock: sample after the falling edge and compare every due entry.
    task automatic tick();
        exp_t keep[$];
        @(negedge clk);
        cyc++;
        keep = {};
        foreach (sb_q[k]) begin
            if (sb_q[k].cyc == cyc) check_val(sb_q[k].tag, observed(sb_q[k].sig), sb_q[k].val);
            else keep.push_back(sb_q[k]);
        end
        sb_q = keep;
    endtask

    // Whole-bus step held long enough to settle. Raw changes just before edge 0
    // (cycle n+1); the clean level lands at edge STABLE+1 (cycle n+6).
    task automatic level_change(input string tag, input logic [7:0] old_v,
                                input logic [7:0] new_v);
        logic [7:0] up;
        logic [7:0] dn;
        logic       any;
        int         n;
        up  = new_v & ~old_v;
        dn  = old_v & ~new_v;
        any = |(up | dn);
        n   = cyc;
        sw_raw = new_v;
        push(n + 2, tag, SIG_BUSY, 8'h00);
        push(n + 3, tag, SIG_BUSY, {7'b0, any});
        push_all(n + 5, tag, old_v, 8'h00, 8'h00, 1'b0, any);
        push_all(n + 6, tag, new_v, up, dn, any, 1'b0);
        push_all(n + 7, tag, new_v, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (9) tick();
    endtask

    initial begin
        int n;

        // Reset held with all switches high: every output stays 0.
        rst    = 1'b1;
        sw_raw = 8'hFF;
        for (int c = 1; c <= 3; c++) push_all(c, "rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        rst    = 1'b0;
        sw_raw = 8'h00;
        for (int c = 4; c <= 8; c++) push_all(c, "idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (6) tick();

        level_change("t2_b3", 8'h00, 8'h08);
        level_change("t4_clr", 8'h08, 8'h00);
        level_change("t4_a5", 8'h00, 8'hA5);
        level_change("t5_ff", 8'hA5, 8'hFF);
        level_change("t5_7f", 8'hFF, 8'h7F);
        level_change("mix", 8'h7F, 8'h80);

        // Bounce on bit1: high 3 cycles, low 1, then high. The low cycle arrives
        // at the edge that would otherwise have committed, resetting the count.
        n = cyc;
        sw_raw = 8'h82;
        for (int c = n + 1; c <= n + 9; c++)
            push_all(c, "bounce", 8'h80, 8'h00, 8'h00, 1'b0, (c >= n + 3) && (c != n + 6));
        push_all(n + 10, "bounce", 8'h82, 8'h02, 8'h00, 1'b1, 1'b0);
        push_all(n + 11, "bounce", 8'h82, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        sw_raw = 8'h80;
        tick();
        sw_raw = 8'h82;
        repeat (8) tick();

        level_change("t6_clr", 8'h82, 8'h00);

        // Reset mid-debounce on bit0: partial count discarded, full latency again.
        n = cyc;
        sw_raw = 8'h01;
        push(n + 3, "rstmid", SIG_BUSY, 8'h01);
        push_all(n + 4, "rstmid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int c = n + 5; c <= n + 9; c++)
            push_all(c, "rstmid", 8'h00, 8'h00, 8'h00, 1'b0, c >= n + 7);
        push_all(n + 10, "rstmid", 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        push_all(n + 11, "rstmid", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();

        check_val("sb_drain", 8'(sb_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
